cdc_event_scheduler: RTL and testbench
======================================

CDC_EVENT_SCHEDULER -- requirements
Module: cdc_event_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of event requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, giving the clockIn cycles allowed for an acknowledge (1..255).
REQ-003 The block SHALL have parameter GUARD, default 2, giving the idle clockIn cycles enforced between launches (1..15).
REQ-004 clockIn  input  1  sole clock; all logic is in the clockIn domain.
REQ-005 s_reset0  input  1  reset; asynchronous, active-high.
REQ-006 reqIn  input  NREQ  per-requester event strobe, one bit per requester, sampled every edge.
REQ-007 ackIn  input  1  completion pulse, already synchronized back into clockIn.
REQ-008 clearIn  input  1  one-cycle clear of sticky flags.
REQ-009 pulseOut  output  1  one-cycle launch pulse driving the shared crossing channel D input.
REQ-010 eventIdOut  output  3  index of the granted requester, held stable from launch until the end of GUARD.
REQ-011 doneOut  output  NREQ  one-cycle completion strobe per requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 overflow  output  NREQ  sticky flag per requester: event dropped.
REQ-014 timeoutErr  output  1  sticky flag: acknowledge not received.

Function
REQ-015 The block SHALL keep one pending bit per requester; reqIn[i]=1 sets pending[i] on the next edge.
REQ-016 reqIn[i] while pending[i]=1 and not being cleared that cycle SHALL drop the event and set overflow[i].
REQ-017 reqIn[i] in the same cycle pending[i] is cleared SHALL leave pending[i]=1 with no overflow (set wins).
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT_ACK and GUARD.
REQ-019 IDLE -> LAUNCH when any pending bit is 1; eventIdOut latches the round-robin winner on that edge.
REQ-020 Round-robin search SHALL start at pointer ptr (reset 0) and scan ptr, ptr+1, ... modulo NREQ; ptr becomes winner+1 on grant.
REQ-021 In LAUNCH, pulseOut SHALL be 1 for exactly that one cycle, then WAIT_ACK, with the timeout counter loaded with TIMEOUT.
REQ-022 Latency: reqIn sampled at edge t while in IDLE with nothing pending -> pulseOut high in the cycle after edge t+2.
REQ-023 In WAIT_ACK, ackIn=1 SHALL clear pending[eventIdOut], pulse doneOut[eventIdOut] for one cycle, and go to GUARD.
REQ-024 In WAIT_ACK, the counter SHALL decrement each cycle without ackIn; at 0 the block SHALL set timeoutErr, leave pending set, and go to GUARD.
REQ-025 ackIn and counter expiry in the same cycle SHALL be treated as ack, with no timeoutErr.
REQ-026 ackIn outside WAIT_ACK SHALL be ignored.
REQ-027 GUARD SHALL last exactly GUARD cycles with pulseOut=0, then go to IDLE.
REQ-028 clearIn=1 SHALL zero overflow and timeoutErr; a set event in the same cycle SHALL win.
REQ-029 pulseOut and doneOut SHALL be registered outputs.

Reset
REQ-030 When s_reset0=1, the block SHALL immediately force: state IDLE, pending=0, ptr=0, counter=0, pulseOut=0, eventIdOut=0, doneOut=0, busy=0, overflow=0, timeoutErr=0.
REQ-031 Reset asserted mid-WAIT_ACK SHALL abandon the transfer with no doneOut, and any later ackIn SHALL be ignored.

Verification
REQ-032 Single event: reqIn=0001 at edge 0 with ack 3 cycles after pulse -> pulseOut in cycle 2, eventIdOut=0, doneOut=0001 once, busy low after GUARD=2.
REQ-033 Fairness: reqIn=1111 for one cycle, immediate acks -> launches in order id 0,1,2,3, each separated by >=GUARD+1 idle cycles without pulse.
REQ-034 Overflow: reqIn[2] pulsed twice while pending[2]=1 -> overflow=0100 sticky, only one launch for id 2; clearIn -> overflow=0000.
REQ-035 Timeout: no ackIn, TIMEOUT=64 -> timeoutErr=1 after 64 WAIT_ACK cycles, pending kept, relaunch of the same id after GUARD if no other pending.
REQ-036 Set-wins: reqIn[1] in the same cycle ackIn completes id 1 -> doneOut=0010, pending[1] stays 1, second launch for id 1, overflow=0.
REQ-037 Reset mid-transfer: s_reset0 pulsed during WAIT_ACK -> all outputs 0 immediately, a following ackIn produces no doneOut.

Source files
------------

// File: rtl/cdc_event_scheduler.sv
// rtl/cdc_event_scheduler.sv - round-robin event launcher for a shared CDC pulse channel
module cdc_event_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int GUARD   = 2
) (
  input  logic            clockIn,
  input  logic            s_reset0,
  input  logic [NREQ-1:0] reqIn,
  input  logic            ackIn,
  input  logic            clearIn,
  output logic            pulseOut,
  output logic [2:0]      eventIdOut,
  output logic [NREQ-1:0] doneOut,
  output logic            busy,
  output logic [NREQ-1:0] overflow,
  output logic            timeoutErr
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;
  localparam logic [1:0] ST_GUARD    = 2'd3;

  logic [1:0]      state;
  logic [NREQ-1:0] pending;
  logic [2:0]      ptr;
  logic [7:0]      ack_cnt;
  logic [3:0]      guard_cnt;

  logic [7:0]      pend_pad;
  logic [3:0]      scan_idx;
  logic [2:0]      winner;
  logic            found;
  logic [2:0]      next_ptr;
  logic            ack_hit;
  logic            expire;
  logic [NREQ-1:0] clr_mask;
  logic [NREQ-1:0] drop_mask;

  // Pad pending to eight bits so the scan can index it with a 3-bit id.
  always_comb begin
    pend_pad = '0;
    pend_pad[NREQ-1:0] = pending;
  end

  // Round-robin search starting at ptr, wrapping modulo NREQ.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr} + 4'(k);
      if (scan_idx >= 4'(NREQ)) scan_idx = scan_idx - 4'(NREQ);
      if (!found && pend_pad[scan_idx[2:0]]) begin
        found  = 1'b1;
        winner = scan_idx[2:0];
      end
    end
  end

  assign next_ptr = (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;

  // An acknowledge takes priority over counter expiry in the same cycle.
  assign ack_hit = (state == ST_WAIT_ACK) && ackIn;
  assign expire  = (state == ST_WAIT_ACK) && !ackIn && (ack_cnt == 8'd1);

  // Decode the granted id into the per-requester clear mask.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      clr_mask[i] = ack_hit && (eventIdOut == 3'(i));
    end
  end

  assign drop_mask = reqIn & pending & ~clr_mask;
  assign busy      = (state != ST_IDLE);

  // Pending bits: a new request always sets, an acknowledge clears the granted id.
  always_ff @(posedge clockIn or posedge s_reset0) begin
    if (s_reset0) begin
      pending <= '0;
    end else begin
      pending <= reqIn | (pending & ~clr_mask);
    end
  end

  // Sticky error flags; a new error in the same cycle as clearIn wins.
  always_ff @(posedge clockIn or posedge s_reset0) begin
    if (s_reset0) begin
      overflow   <= '0;
      timeoutErr <= 1'b0;
    end else begin
      overflow   <= (clearIn ? '0 : overflow) | drop_mask;
      timeoutErr <= (timeoutErr & ~clearIn) | expire;
    end
  end

  // Launch sequencer: grant, launch, wait for ack or expiry, then guard gap.
  always_ff @(posedge clockIn or posedge s_reset0) begin
    if (s_reset0) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      eventIdOut <= '0;
      ack_cnt    <= '0;
      guard_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state      <= ST_LAUNCH;
            eventIdOut <= winner;
            ptr        <= next_ptr;
          end
        end
        ST_LAUNCH: begin
          state   <= ST_WAIT_ACK;
          ack_cnt <= 8'(TIMEOUT);
        end
        ST_WAIT_ACK: begin
          if (!ackIn) ack_cnt <= ack_cnt - 8'd1;
          if (ack_hit || expire) begin
            state     <= ST_GUARD;
            guard_cnt <= 4'(GUARD);
          end
        end
        ST_GUARD: begin
          guard_cnt <= guard_cnt - 4'd1;
          if (guard_cnt == 4'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered strobes: the launch pulse follows LAUNCH, done follows the ack.
  always_ff @(posedge clockIn or posedge s_reset0) begin
    if (s_reset0) begin
      pulseOut <= 1'b0;
      doneOut  <= '0;
    end else begin
      pulseOut <= (state == ST_LAUNCH);
      doneOut  <= clr_mask;
    end
  end

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// tb/tb_cdc_event_scheduler.sv - randomized scoreboard bench for cdc_event_scheduler
module tb_cdc_event_scheduler;

  localparam int N   = 4;
  localparam int TMO = 64;
  localparam int GRD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         clr = 1'b0;
  logic         pulse;
  logic [2:0]   eid;
  logic [N-1:0] done;
  logic         busy_o;
  logic [N-1:0] ovf;
  logic         terr;

  cdc_event_scheduler #(.NREQ(N), .TIMEOUT(TMO), .GUARD(GRD)) dut (
    .clockIn(clk), .s_reset0(rst), .reqIn(req), .ackIn(ack), .clearIn(clr),
    .pulseOut(pulse), .eventIdOut(eid), .doneOut(done), .busy(busy_o),
    .overflow(ovf), .timeoutErr(terr)
  );

  always #5 clk = ~clk;

  // Edge counter: value after an edge is that edge's index.
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct { int cyc; int id; } pulse_t;
  typedef struct { int cyc; logic [N-1:0] mask; } done_t;
  typedef struct { int cyc; bit busy; logic [N-1:0] ovf; bit terr; logic [2:0] eid; } snap_t;

  pulse_t pq[$];
  done_t  dq[$];
  snap_t  sq[$];

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  // Reference model: absolute edge timeline of the current transfer.
  logic [N-1:0] m_pend, m_ovf;
  bit           m_terr, m_xfer;
  int           m_ptr, m_gid, m_gedge, m_idle;
  logic [2:0]   m_eid;

  int ack_mode;
  int ack_delay;
  int ack_pct;
  bit echo_en;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecnt, got, exp);
  endtask

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_terr = 1'b0; m_xfer = 1'b0;
    m_ptr = 0; m_gid = 0; m_gedge = 0; m_idle = -100; m_eid = 3'd0;
  endtask

  // Effect of edge x given the inputs sampled there.
  task automatic model_edge(input int x, input logic [N-1:0] rq, input bit ak, input bit cl);
    logic [N-1:0] cm, sh;
    bit to, got;
    int id;
    cm = '0; to = 1'b0; got = 1'b0;
    if (!m_xfer && x > m_idle && m_pend != '0) begin
      for (int k = 0; k < N; k++) begin
        id = (m_ptr + k) % N;
        sh = m_pend >> id;
        if (!got && sh[0]) begin
          got = 1'b1;
          m_gid = id;
        end
      end
      m_ptr = (m_gid + 1) % N;
      m_xfer = 1'b1;
      m_gedge = x;
      m_eid = 3'(m_gid);
      pq.push_back('{x + 1, m_gid});
    end else if (m_xfer && x >= m_gedge + 2) begin
      if (ak) begin
        cm = N'(1) << m_gid;
        dq.push_back('{x, cm});
        m_xfer = 1'b0;
        m_idle = x + GRD;
      end else if (x == m_gedge + 1 + TMO) begin
        to = 1'b1;
        m_xfer = 1'b0;
        m_idle = x + GRD;
      end
    end
    m_ovf  = (cl ? '0 : m_ovf) | (rq & m_pend & ~cm);
    m_terr = (m_terr && !cl) || to;
    m_pend = rq | (m_pend & ~cm);
    sq.push_back('{x, (m_xfer || (x < m_idle)), m_ovf, m_terr, m_eid});
  endtask

  task automatic step(input logic [N-1:0] rq_in, input bit cl);
    int nx;
    bit ak;
    logic [N-1:0] rq;
    @(posedge clk);
    #2;
    rq = rq_in;
    nx = ecnt + 1;
    case (ack_mode)
      0: ak = m_xfer && (nx == m_gedge + 1 + ack_delay);
      1: ak = (int'($urandom_range(99)) < ack_pct);
      default: ak = 1'b0;
    endcase
    if (echo_en && ak && m_xfer && nx >= m_gedge + 2) rq = rq | (N'(1) << m_gid);
    req = rq; ack = ak; clr = cl;
    model_edge(nx, rq, ak, cl);
  endtask

  task automatic rst_step();
    @(posedge clk);
    #2;
    rst = 1'b1; req = '0; ack = 1'b0; clr = 1'b0;
    #1;
    chk("reset_outputs", 32'({pulse, eid, done, busy_o, ovf, terr}), 32'd0);
    rst = 1'b0;
    pq.delete(); dq.delete(); sq.delete();
    model_reset();
    sq.push_back('{ecnt, 1'b0, '0, 1'b0, 3'd0});
    model_edge(ecnt + 1, '0, 1'b0, 1'b0);
    mon_en = 1'b1;
  endtask

  task automatic mon_cycle();
    int cur;
    snap_t s;
    pulse_t p;
    done_t d;
    cur = ecnt;
    chk("snap_avail", 32'(sq.size() != 0), 32'd1);
    if (sq.size() != 0) begin
      s = sq.pop_front();
      chk("snap_cycle", 32'(cur), 32'(s.cyc));
      chk("busy", 32'(busy_o), 32'(s.busy));
      chk("overflow", 32'(ovf), 32'(s.ovf));
      chk("timeoutErr", 32'(terr), 32'(s.terr));
      chk("eventIdOut", 32'(eid), 32'(s.eid));
    end
    if (pulse) begin
      chk("pulse_expected", 32'(pq.size() != 0), 32'd1);
      if (pq.size() != 0) begin
        p = pq.pop_front();
        chk("pulse_cycle", 32'(cur), 32'(p.cyc));
        chk("pulse_id", 32'(eid), 32'(p.id));
      end
    end else if (pq.size() != 0 && pq[0].cyc <= cur) begin
      chk("pulse_missing", 32'(pulse), 32'd1);
      p = pq.pop_front();
    end
    if (done != '0) begin
      chk("done_expected", 32'(dq.size() != 0), 32'd1);
      if (dq.size() != 0) begin
        d = dq.pop_front();
        chk("done_cycle", 32'(cur), 32'(d.cyc));
        chk("done_mask", 32'(done), 32'(d.mask));
      end
    end else if (dq.size() != 0 && dq[0].cyc <= cur) begin
      chk("done_missing", 32'(done), 32'(dq[0].mask));
      d = dq.pop_front();
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) mon_cycle();
    end
  end

  initial begin
    logic [N-1:0] r;
    model_reset();
    ack_mode = 0; ack_delay = 3; ack_pct = 0; echo_en = 1'b0;
    #1 rst = 1'b1;
    rst_step();

    // Single event, ack three cycles after the pulse.
    step(4'b0001, 1'b0);
    repeat (14) step('0, 1'b0);

    // All four at once with immediate acks.
    ack_delay = 1;
    step(4'b1111, 1'b0);
    repeat (40) step('0, 1'b0);

    // Repeat requests on id 2 while pending, then clear.
    ack_delay = 4;
    step(4'b0100, 1'b0);
    step('0, 1'b0);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b0);
    repeat (12) step('0, 1'b0);
    step('0, 1'b1);
    repeat (3) step('0, 1'b0);

    // No ack: expiry, then relaunch of the same id is acknowledged.
    ack_mode = 2;
    step(4'b0001, 1'b0);
    repeat (TMO + 3) step('0, 1'b0);
    ack_mode = 0; ack_delay = 2;
    repeat (15) step('0, 1'b0);
    step('0, 1'b1);
    step('0, 1'b0);

    // New request for id 1 in the cycle its ack arrives.
    ack_delay = 3; echo_en = 1'b1;
    step(4'b0010, 1'b0);
    repeat (8) step('0, 1'b0);
    echo_en = 1'b0;
    repeat (14) step('0, 1'b0);

    // Reset while waiting for ack, then stray acks.
    ack_mode = 2;
    step(4'b0001, 1'b0);
    repeat (5) step('0, 1'b0);
    rst_step();
    ack_mode = 1; ack_pct = 100;
    repeat (6) step('0, 1'b0);

    // Random traffic with varying ack rates.
    for (int seg = 0; seg < 4; seg++) begin
      ack_mode = 1;
      ack_pct = (seg == 0) ? 25 : (seg == 1) ? 5 : (seg == 2) ? 60 : 2;
      for (int i = 0; i < 700; i++) begin
        if ($urandom_range(599) == 0) begin
          rst_step();
        end else begin
          r = '0;
          for (int b = 0; b < N; b++) begin
            if ($urandom_range(99) < 6) r = r | (N'(1) << b);
          end
          echo_en = ($urandom_range(3) == 0);
          step(r, ($urandom_range(49) == 0));
        end
      end
    end

    // Drain everything still pending.
    ack_mode = 0; ack_delay = 1; echo_en = 1'b0;
    repeat (150) step('0, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("pulse_queue_empty", 32'(pq.size()), 32'd0);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("snap_queue_empty", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
